// File: rtl/btn_event_arbiter_if.sv
// UART TX handshake between the button event arbiter (master) and the transmitter (slave).
interface btn_event_arbiter_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/btn_event_arbiter.sv
// Queues one press event per button and sends P_BASE_CHAR+index over a shared UART TX, round-robin.
// Optional macro BTN_ARB_OVF_EN adds sticky per-button lost-press flags on port ovf.
module btn_event_arbiter #(
    parameter int         P_NUM_BTN     = 4,
    parameter logic [7:0] P_BASE_CHAR   = 8'h30,
    parameter int         P_ACK_TIMEOUT = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [P_NUM_BTN-1:0] btn_pulse,
    btn_event_arbiter_if.master  tx,
    output logic [P_NUM_BTN-1:0] pending,
    output logic                 busy
`ifdef BTN_ARB_OVF_EN
    ,
    output logic [P_NUM_BTN-1:0] ovf
`endif
);

    localparam int PW = $clog2(P_NUM_BTN);
    localparam int CW = $clog2(P_ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [P_NUM_BTN-1:0] r_pending;
    logic [PW-1:0]        r_rr_ptr;
    logic [PW-1:0]        r_grant;
    logic [7:0]           r_tx_data;
    logic [CW-1:0]        r_cnt;

    logic [PW-1:0]        w_grant;
    logic                 w_load;
    logic                 w_retry;
    logic                 w_tx_start;
    logic [P_NUM_BTN-1:0] w_clr;
    logic [P_NUM_BTN-1:0] w_rset;

    // Descending scan so the lowest offset from ptr is the last (winning) assignment.
    function automatic logic [PW-1:0] f_pick(input logic [P_NUM_BTN-1:0] req,
                                             input logic [PW-1:0] ptr);
        logic [PW-1:0] g;
        int            idx;
        g = ptr;
        for (int k = P_NUM_BTN - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= P_NUM_BTN) idx = idx - P_NUM_BTN;
            if (req[idx]) g = PW'(idx);
        end
        return g;
    endfunction

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] g);
        int n;
        n = int'(g) + 1;
        if (n >= P_NUM_BTN) n = 0;
        return PW'(n);
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_retry      = 1'b0;
        w_tx_start   = 1'b0;
        w_grant      = f_pick(r_pending, r_rr_ptr);
        case (r_state)
            S_IDLE: begin
                if ((|r_pending) && !tx.tx_busy) begin
                    w_load       = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_tx_start   = 1'b1;
                w_state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx.tx_busy) begin
                    w_state_next = S_WAIT_DONE;
                end else if (r_cnt == CW'(P_ACK_TIMEOUT - 1)) begin
                    w_retry      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx.tx_busy) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_clr  = w_load  ? (P_NUM_BTN'(1) << w_grant) : '0;
    assign w_rset = w_retry ? (P_NUM_BTN'(1) << r_grant) : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_tx_data <= '0;
            r_cnt     <= '0;
        end else begin
            // A press or retry on the clearing edge keeps the bit queued.
            r_pending <= (r_pending & ~w_clr) | btn_pulse | w_rset;
            if (w_load) begin
                r_grant   <= w_grant;
                r_rr_ptr  <= f_next(w_grant);
                r_tx_data <= P_BASE_CHAR + 8'(w_grant);
            end
            if (r_state == S_LOAD)
                r_cnt <= '0;
            else if (r_state == S_WAIT_ACK && !tx.tx_busy && !w_retry)
                r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef BTN_ARB_OVF_EN
    logic [P_NUM_BTN-1:0] r_ovf;

    always_ff @(posedge CLK) begin
        if (RST) r_ovf <= '0;
        else     r_ovf <= r_ovf | (btn_pulse & r_pending & ~w_clr);
    end

    assign ovf = r_ovf;
`endif

    assign tx.tx_start = w_tx_start;
    assign tx.tx_data  = r_tx_data;
    assign pending     = r_pending;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: table of press patterns plus hand-timed corner sequences.
module tb_btn_event_arbiter;

    typedef struct {
        logic       do_rst;
        logic [3:0] pulse;
        int         n;
        logic [7:0] exp_b [4];
    } vec_t;

    logic       CLK;
    logic       RST;
    logic [3:0] btn_pulse;
    logic [3:0] pending;
    logic       busy;
`ifdef BTN_ARB_OVF_EN
    logic [3:0] ovf;
`endif

    btn_event_arbiter_if u_if ();

    btn_event_arbiter #(
        .P_NUM_BTN    (4),
        .P_BASE_CHAR  (8'h30),
        .P_ACK_TIMEOUT(16)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .btn_pulse(btn_pulse),
        .tx       (u_if),
        .pending  (pending),
        .busy     (busy)
`ifdef BTN_ARB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_starts = 0;
    logic [7:0] q_bytes [$];
    logic       prev_start = 1'b0;
    vec_t       vecs [8];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Capture every transmitted byte mid-cycle and reject back-to-back starts.
    always @(negedge CLK) begin
        if (u_if.tx_start === 1'b1) begin
            check("tx_start_not_consecutive", {31'd0, prev_start}, 32'd0);
            q_bytes.push_back(u_if.tx_data);
            n_starts++;
        end
        prev_start = u_if.tx_start;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST          = 1'b1;
        btn_pulse    = '0;
        u_if.tx_busy = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        q_bytes.delete();
    endtask

    task automatic pulse(input logic [3:0] m);
        btn_pulse = m;
        tick();
        btn_pulse = '0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (u_if.tx_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("tx_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic serve(input int n, input int hold);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_start(ok);
            if (!ok) return;
            u_if.tx_busy = 1'b1;
            repeat (hold) tick();
            u_if.tx_busy = 1'b0;
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] p, input int n,
                                input logic [7:0] a, input logic [7:0] b = 8'h00,
                                input logic [7:0] c = 8'h00, input logic [7:0] d = 8'h00);
        vec_t v;
        v.do_rst   = r;
        v.pulse    = p;
        v.n        = n;
        v.exp_b[0] = a;
        v.exp_b[1] = b;
        v.exp_b[2] = c;
        v.exp_b[3] = d;
        return v;
    endfunction

    function automatic logic [31:0] q_at(input int i);
        return (i < q_bytes.size()) ? {24'd0, q_bytes[i]} : 32'hDEAD;
    endfunction

    initial begin
        vec_t v;
        int   n0;

        vecs[0] = mk(1'b1, 4'b0100, 1, 8'h32);
        vecs[1] = mk(1'b1, 4'b1011, 3, 8'h30, 8'h31, 8'h33);
        vecs[2] = mk(1'b0, 4'b1111, 4, 8'h30, 8'h31, 8'h32, 8'h33);
        vecs[3] = mk(1'b1, 4'b1000, 1, 8'h33);
        vecs[4] = mk(1'b0, 4'b1001, 2, 8'h30, 8'h33);
        vecs[5] = mk(1'b1, 4'b0010, 1, 8'h31);
        vecs[6] = mk(1'b0, 4'b0111, 3, 8'h32, 8'h30, 8'h31);
        vecs[7] = mk(1'b0, 4'b1100, 2, 8'h32, 8'h33);

        RST          = 1'b1;
        btn_pulse    = '0;
        u_if.tx_busy = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_tx_start", u_if.tx_start, 0);
        check("rst_tx_data", u_if.tx_data, 0);
`ifdef BTN_ARB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        RST = 1'b0;
        q_bytes.delete();

        // Single press: exact cycle-by-cycle latency and busy release.
        pulse(4'b0100);
        check("t1_pending_set", pending, 4'b0100);
        check("t1_busy_idle", busy, 0);
        tick();
        check("t1_tx_start", u_if.tx_start, 1);
        check("t1_tx_data", u_if.tx_data, 8'h32);
        check("t1_pending_clr", pending, 0);
        check("t1_busy_load", busy, 1);
        u_if.tx_busy = 1'b1;
        repeat (10) tick();
        check("t1_busy_done", busy, 1);
        u_if.tx_busy = 1'b0;
        tick();
        check("t1_busy_fall", busy, 0);
        repeat (20) tick();
        check("t1_num_bytes", q_bytes.size(), 1);

        for (int vi = 0; vi < 8; vi++) begin
            v = vecs[vi];
            if (v.do_rst) do_reset();
            q_bytes.delete();
            pulse(v.pulse);
            serve(v.n, 3);
            repeat (30) tick();
            check($sformatf("vec%0d_num_bytes", vi), q_bytes.size(), v.n);
            for (int i = 0; i < v.n; i++)
                check($sformatf("vec%0d_byte%0d", vi, i), q_at(i), {24'd0, v.exp_b[i]});
            check($sformatf("vec%0d_pending", vi), pending, 0);
            check($sformatf("vec%0d_busy", vi), busy, 0);
        end

        // No ack: retry after 16 cycles in WAIT_ACK with the same byte.
        do_reset();
        pulse(4'b0001);
        tick();
        check("to_tx_start1", u_if.tx_start, 1);
        check("to_tx_data1", u_if.tx_data, 8'h30);
        repeat (16) tick();
        check("to_pending_wait", pending, 0);
        check("to_busy_wait", busy, 1);
        tick();
        check("to_pending_retry", pending, 4'b0001);
        check("to_busy_retry", busy, 0);
        tick();
        check("to_tx_start2", u_if.tx_start, 1);
        check("to_tx_data2", u_if.tx_data, 8'h30);
        u_if.tx_busy = 1'b1;
        repeat (3) tick();
        u_if.tx_busy = 1'b0;
        repeat (30) tick();
        check("to_num_bytes", q_bytes.size(), 2);
        check("to_pending_end", pending, 0);

        // Reset while in WAIT_DONE abandons the transfer and the queue.
        do_reset();
        pulse(4'b0100);
        tick();
        check("rm_tx_start", u_if.tx_start, 1);
        u_if.tx_busy = 1'b1;
        tick();
        tick();
        pulse(4'b0011);
        check("rm_pending_pre", pending, 4'b0011);
        check("rm_busy_pre", busy, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rm_busy", busy, 0);
        check("rm_pending", pending, 0);
        check("rm_tx_start_low", u_if.tx_start, 0);
        n0 = n_starts;
        repeat (3) tick();
        u_if.tx_busy = 1'b0;
        repeat (30) tick();
        check("rm_no_more_start", n_starts - n0, 0);

        // Two presses of button 1 while the UART is busy: one byte, lost press flagged.
        do_reset();
        u_if.tx_busy = 1'b1;
        pulse(4'b0010);
        tick();
        tick();
        pulse(4'b0010);
        check("ov_pending", pending, 4'b0010);
        check("ov_busy", busy, 0);
`ifdef BTN_ARB_OVF_EN
        check("ov_flag", ovf, 4'b0010);
`endif
        u_if.tx_busy = 1'b0;
        serve(1, 3);
        repeat (30) tick();
        check("ov_num_bytes", q_bytes.size(), 1);
        check("ov_byte", q_at(0), 32'h31);
`ifdef BTN_ARB_OVF_EN
        check("ov_flag_sticky", ovf, 4'b0010);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Collects one-cycle press pulses from P_NUM_BTN debounced buttons and queues one pending event per button.
- Shares the single UART transmitter between the buttons using round-robin arbitration.
- Sends one ASCII byte per press (P_BASE_CHAR + button index) through a start/busy handshake.
- Sits between the per-button debouncers and the UART TX block.

Parameters:
- P_NUM_BTN, 4: number of button inputs; legal range 2..16.
- P_BASE_CHAR, 8'h30: byte sent for button 0. Button i sends P_BASE_CHAR + i, modulo 256.
- P_ACK_TIMEOUT, 16: cycles to wait in WAIT_ACK for tx_busy to rise before retrying; must be ≥ 2.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- btn_pulse  in  P_NUM_BTN  one-cycle press pulses, one bit per button.
- tx_busy  in  1  UART TX busy flag: high while a byte is being shifted out.
- tx_start  out  1  one-cycle request to the UART TX to send tx_data.
- tx_data  out  8  byte to transmit.
- pending  out  P_NUM_BTN  queued, not-yet-sent events.
- busy  out  1  high when the state machine is not in IDLE.
- ovf  out  P_NUM_BTN  sticky lost-press flags; present only with BTN_ARB_OVF_EN.

Behaviour:
- Reset, when RST is sampled high on any edge, including mid-transfer:
  - state = IDLE; pending, rr_ptr, tx_start, tx_data, timeout counter and ovf all 0.
  - Any transfer in flight is abandoned; no tx_start is issued afterwards.
- Pending register:
  - bit i is set on any edge where btn_pulse[i] = 1.
  - bit i is cleared on the edge that enters LOAD for index i.
  - If set and clear happen on the same edge, set wins: the press stays queued.
- Round-robin pointer rr_ptr, width clog2(P_NUM_BTN):
  - Search starts at rr_ptr and wraps from P_NUM_BTN-1 to 0.
  - After a grant to index g, rr_ptr = (g+1) mod P_NUM_BTN.
- State machine:
  - IDLE: if pending != 0 and tx_busy = 0, latch grant index g = first set bit at or after rr_ptr and go to LOAD. If tx_busy = 1, stay in IDLE.
  - LOAD (1 cycle): tx_start = 1 and tx_data = P_BASE_CHAR + g. Clear pending[g], update rr_ptr, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK:
    - tx_busy = 1 → WAIT_DONE.
    - Otherwise increment the counter. When the counter reaches P_ACK_TIMEOUT-1, set pending[g] again (retry) and go to IDLE.
  - WAIT_DONE: tx_busy = 0 → IDLE.
- Outputs:
  - tx_start is high only in LOAD; never high on two consecutive cycles.
  - tx_data is registered and held from LOAD until the next LOAD.
  - busy = (state != IDLE).
- Latency: pulse sampled at edge t, FSM idle, tx_busy low → pending high after edge t, LOAD entered at edge t+1, so tx_start is high in the cycle after edge t+1.
- Multiple simultaneous pulses: all bits are queued and served in round-robin order, one byte per transfer.
- The design must not deadlock if tx_busy never rises (timeout path) or never falls. Holding in WAIT_DONE while tx_busy stays high is the intended behaviour.

Optional Feature:
- Macro: BTN_ARB_OVF_EN.
- Defined:
  - ovf port exists.
  - ovf[i] is set when btn_pulse[i] = 1 while pending[i] is already 1 and is not being cleared on that edge (the press is lost).
  - Sticky; cleared only by RST.
- Undefined: ovf port and all its logic are absent; lost presses are silently merged.

Test Plan:
- Reset then btn_pulse = 4'b0100 for one cycle, tx_busy tied low until tx_start, then high for 10 cycles → exactly one tx_start pulse with tx_data = 8'h32; pending returns to 0; busy falls the cycle after tx_busy falls.
- btn_pulse = 4'b1011 in a single cycle, each transfer acked → bytes 8'h30, 8'h31, 8'h33 in that order; rr_ptr ends at 0.
- Pulse button 3, complete its transfer, then pulse buttons 0 and 3 together → order 8'h30 then 8'h33, confirming round-robin wrap.
- tx_busy held at 0 after tx_start → after 16 cycles in WAIT_ACK, pending[g] is set again and a second tx_start with the same tx_data follows.
- RST asserted for one cycle while in WAIT_DONE with pending = 4'b0011 → next cycle busy = 0, pending = 0, tx_start = 0; no further tx_start after tx_busy falls.
- With BTN_ARB_OVF_EN defined, hold tx_busy = 1 and pulse button 1 twice, 3 cycles apart → ovf = 4'b0010 and only one 8'h31 is sent once tx_busy drops. Without the macro the same stimulus sends one 8'h31 and the ovf port is absent.
